// File: rtl/coef_bank.sv
// coef_bank: double-buffered FIR coefficient store.
// A serial loader fills the shadow bank while the active bank streams taps to the MAC.
// A full shadow bank is swapped in atomically, but only while no sweep is running
// or on the final tap of a sweep. This keeps every sweep internally consistent.
module coef_bank #(
    parameter int               TAP_W       = 16,
    parameter int               N_TAPS      = 16,
    parameter logic [TAP_W-1:0] DEFAULT_TAP = TAP_W'(1),
    parameter int               IDX_W       = $clog2(N_TAPS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_start,
    input  logic             i_load_valid,
    input  logic [TAP_W-1:0] i_load_data,
    output logic             o_load_ready,
    output logic             o_commit_pending,
    output logic             o_swapped,
    output logic             o_bank,
    input  logic             i_rd_start,
    input  logic             i_rd_rev,
    output logic [TAP_W-1:0] o_tap,
    output logic [IDX_W-1:0] o_tap_idx,
    output logic             o_tap_valid,
    output logic             o_tap_last,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_FILL = 2'd1,
        L_PEND = 2'd2
    } load_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    load_state_t      load_state_q, load_state_d;
    logic [IDX_W-1:0] wptr_q, wptr_d;
    logic             bank_q, bank_d;

    rd_state_t        rd_state_q, rd_state_d;
    logic             sweep_bank_q, sweep_bank_d;
    logic             rev_q, rev_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [IDX_W-1:0] tap_idx_q, tap_idx_d;
    logic             tap_valid_q, tap_valid_d;
    logic             tap_last_q, tap_last_d;

    // Write port and swap control
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             wr_bank;
    logic             swap;

    // Read port
    logic             rd_accept;
    logic             rd_bank_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] step_idx;
    logic [IDX_W-1:0] end_idx;

    // Flattened view of both banks for the readout mux
    logic [TAP_W-1:0] tap_arr [2][N_TAPS];

    // The loader always targets the bank that is not being read
    assign wr_bank = ~bank_q;

    // ------------------------------------------------------------------
    // Coefficient storage: one register per tap and bank. The registers
    // need a reset value, so the store is built from flops, not RAM.
    // ------------------------------------------------------------------
    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
            logic [TAP_W-1:0] cell_q, cell_d;

            // Capture the load word when this cell is the write target
            always_comb begin
                cell_d = cell_q;
                if (wr_en && (wr_bank == 1'(gb)) && (wr_addr == IDX_W'(gi))) begin
                    cell_d = i_load_data;
                end
            end

            // Cell register; reset restores the default coefficient
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cell_q <= DEFAULT_TAP;
                end else begin
                    cell_q <= cell_d;
                end
            end

            assign tap_arr[gb][gi] = cell_q;
        end
    end

    // ------------------------------------------------------------------
    // Load FSM next state: fill the shadow bank, then wait for a safe swap point
    // ------------------------------------------------------------------
    always_comb begin
        load_state_d = load_state_q;
        wptr_d       = wptr_q;
        wr_en        = 1'b0;
        wr_addr      = wptr_q;
        swap         = 1'b0;

        if (i_load_start) begin
            // A start always (re)opens the fill at index 0.
            // Any pending commit is dropped.
            load_state_d = L_FILL;
            wptr_d       = '0;
            if ((load_state_q != L_IDLE) && i_load_valid) begin
                // A restart with valid data writes that word to index 0
                wr_en   = 1'b1;
                wr_addr = '0;
                wptr_d  = IDX_W'(1);
            end
        end else begin
            case (load_state_q)
                L_FILL: begin
                    if (i_load_valid) begin
                        wr_en = 1'b1;
                        if (wptr_q == LAST_IDX) begin
                            load_state_d = L_PEND;
                            wptr_d       = '0;
                        end else begin
                            wptr_d = wptr_q + IDX_W'(1);
                        end
                    end
                end
                L_PEND: begin
                    // Swap only when no sweep would see a mid-sweep bank change
                    if ((rd_state_q == R_IDLE) || tap_last_q) begin
                        swap         = 1'b1;
                        load_state_d = L_IDLE;
                    end
                end
                default: begin
                    load_state_d = load_state_q;
                end
            endcase
        end
    end

    // Toggle the bank pointer on a swap
    always_comb begin
        bank_d = bank_q ^ swap;
    end

    // ------------------------------------------------------------------
    // Read FSM next state: registered sweep over the active bank
    // ------------------------------------------------------------------
    // Accept a start when idle, or on the last tap so sweeps can run back to back
    assign rd_accept = i_rd_start && ((rd_state_q == R_IDLE) || tap_last_q);
    assign step_idx  = rev_q ? (tap_idx_q - IDX_W'(1)) : (tap_idx_q + IDX_W'(1));
    assign end_idx   = rev_q ? '0 : LAST_IDX;

    // Sequence the tap index and fetch the next coefficient
    always_comb begin
        rd_state_d   = rd_state_q;
        sweep_bank_d = sweep_bank_q;
        rev_d        = rev_q;
        tap_d        = tap_q;
        tap_idx_d    = tap_idx_q;
        tap_valid_d  = tap_valid_q;
        tap_last_d   = tap_last_q;
        rd_bank_sel  = sweep_bank_q;
        rd_idx       = step_idx;

        if (rd_accept) begin
            // Latch the post-swap bank so a sweep starting with a swap reads the new data
            rd_state_d   = R_RUN;
            sweep_bank_d = bank_d;
            rev_d        = i_rd_rev;
            rd_bank_sel  = bank_d;
            rd_idx       = i_rd_rev ? LAST_IDX : '0;
            tap_d        = tap_arr[rd_bank_sel][rd_idx];
            tap_idx_d    = rd_idx;
            tap_valid_d  = 1'b1;
            tap_last_d   = 1'b0;
        end else if (rd_state_q == R_RUN) begin
            if (tap_last_q) begin
                // Sweep finished with no follow-on start
                rd_state_d  = R_IDLE;
                tap_valid_d = 1'b0;
                tap_last_d  = 1'b0;
            end else begin
                tap_d      = tap_arr[rd_bank_sel][rd_idx];
                tap_idx_d  = step_idx;
                tap_last_d = (step_idx == end_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            load_state_q <= L_IDLE;
            wptr_q       <= '0;
            bank_q       <= 1'b0;
            rd_state_q   <= R_IDLE;
            sweep_bank_q <= 1'b0;
            rev_q        <= 1'b0;
            tap_q        <= '0;
            tap_idx_q    <= '0;
            tap_valid_q  <= 1'b0;
            tap_last_q   <= 1'b0;
        end else begin
            load_state_q <= load_state_d;
            wptr_q       <= wptr_d;
            bank_q       <= bank_d;
            rd_state_q   <= rd_state_d;
            sweep_bank_q <= sweep_bank_d;
            rev_q        <= rev_d;
            tap_q        <= tap_d;
            tap_idx_q    <= tap_idx_d;
            tap_valid_q  <= tap_valid_d;
            tap_last_q   <= tap_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_load_ready     = (load_state_q == L_FILL);
    assign o_commit_pending = (load_state_q == L_PEND);
    assign o_swapped        = swap;
    assign o_bank           = bank_q;
    assign o_tap            = tap_q;
    assign o_tap_idx        = tap_idx_q;
    assign o_tap_valid      = tap_valid_q;
    assign o_tap_last       = tap_last_q;
    assign o_busy           = (rd_state_q == R_RUN);

endmodule

// File: tb/tb_coef_bank.sv
// Directed testbench for coef_bank (16 taps x 16 bits, default tap 1).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_coef_bank;

    localparam int TAP_W  = 16;
    localparam int N_TAPS = 16;
    localparam int IDX_W  = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_load_start;
    logic             i_load_valid;
    logic [TAP_W-1:0] i_load_data;
    logic             o_load_ready;
    logic             o_commit_pending;
    logic             o_swapped;
    logic             o_bank;
    logic             i_rd_start;
    logic             i_rd_rev;
    logic [TAP_W-1:0] o_tap;
    logic [IDX_W-1:0] o_tap_idx;
    logic             o_tap_valid;
    logic             o_tap_last;
    logic             o_busy;

    int n_checks = 0;
    int n_err    = 0;

    coef_bank #(
        .TAP_W      (TAP_W),
        .N_TAPS     (N_TAPS),
        .DEFAULT_TAP(16'd1)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_load_start    (i_load_start),
        .i_load_valid    (i_load_valid),
        .i_load_data     (i_load_data),
        .o_load_ready    (o_load_ready),
        .o_commit_pending(o_commit_pending),
        .o_swapped       (o_swapped),
        .o_bank          (o_bank),
        .i_rd_start      (i_rd_start),
        .i_rd_rev        (i_rd_rev),
        .o_tap           (o_tap),
        .o_tap_idx       (o_tap_idx),
        .o_tap_valid     (o_tap_valid),
        .o_tap_last      (o_tap_last),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_data  = '0;
        i_rd_start   = 1'b0;
        i_rd_rev     = 1'b0;
    endtask

    // One isolated sweep; base < 0 means every tap is the default value 1
    task automatic sweep(input bit rev, input int base, input string tag);
        int idx;
        int exp;
        i_rd_start = 1'b1;
        i_rd_rev   = rev;
        smp();
        next_cyc();
        i_rd_start = 1'b0;
        i_rd_rev   = 1'b0;
        for (int k = 0; k < N_TAPS; k++) begin
            idx = rev ? (N_TAPS - 1 - k) : k;
            exp = (base < 0) ? 1 : (base + idx);
            smp();
            chk({tag, "_valid"}, o_tap_valid, 1);
            chk({tag, "_busy"},  o_busy, 1);
            chk({tag, "_idx"},   o_tap_idx, idx);
            chk({tag, "_tap"},   o_tap, exp);
            chk({tag, "_last"},  o_tap_last, (k == N_TAPS - 1));
            next_cyc();
        end
        smp();
        chk({tag, "_valid_end"}, o_tap_valid, 0);
        chk({tag, "_busy_end"},  o_busy, 0);
        next_cyc();
        $display("sweep %s rev=%0d base=%0d", tag, rev, base);
    endtask

    // Full load with no sweep running; the swap is expected one cycle after the last word
    task automatic load_full(input int base, input bit bank_before, input string tag);
        i_load_start = 1'b1;
        smp();
        next_cyc();
        i_load_start = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 16'(base + i);
            smp();
            chk({tag, "_ready"},   o_load_ready, 1);
            chk({tag, "_pending"}, o_commit_pending, 0);
            next_cyc();
        end
        idle_inputs();
        smp();
        chk({tag, "_pend_set"}, o_commit_pending, 1);
        chk({tag, "_swapped"},  o_swapped, 1);
        chk({tag, "_bank_old"}, o_bank, bank_before);
        chk({tag, "_ready_lo"}, o_load_ready, 0);
        next_cyc();
        smp();
        chk({tag, "_bank_new"},  o_bank, !bank_before);
        chk({tag, "_swap_lo"},   o_swapped, 0);
        chk({tag, "_pend_clr"},  o_commit_pending, 0);
        next_cyc();
        $display("load %s base=%0d", tag, base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        idle_inputs();
        i_rst = 1'b1;

        // ---------------- Reset state ----------------
        next_cyc();
        smp();
        chk("rst_bank",    o_bank, 0);
        chk("rst_ready",   o_load_ready, 0);
        chk("rst_pending", o_commit_pending, 0);
        chk("rst_swapped", o_swapped, 0);
        chk("rst_valid",   o_tap_valid, 0);
        chk("rst_last",    o_tap_last, 0);
        chk("rst_busy",    o_busy, 0);
        chk("rst_tap",     o_tap, 0);
        chk("rst_idx",     o_tap_idx, 0);
        next_cyc();
        i_rst = 1'b0;
        next_cyc();
        $display("reset released");

        // ---------------- Default sweep ----------------
        sweep(1'b0, -1, "dflt");
        smp();
        chk("dflt_bank", o_bank, 0);
        next_cyc();

        // ---------------- Load 100..115, sweep both ways ----------------
        load_full(100, 1'b0, "ld100");
        sweep(1'b0, 100, "asc100");
        sweep(1'b1, 100, "desc100");

        // ---------------- Load finishing mid-sweep ----------------
        // 15 words of 300.. go in first; the last word arrives while a sweep reads the 100s.
        i_load_start = 1'b1;
        smp();
        next_cyc();
        i_load_start = 1'b0;
        for (int i = 0; i < N_TAPS - 1; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 16'(300 + i);
            smp();
            next_cyc();
        end
        idle_inputs();
        smp();
        chk("mid_pre_pending", o_commit_pending, 0);
        chk("mid_pre_ready",   o_load_ready, 1);
        next_cyc();
        i_rd_start = 1'b1;
        smp();
        next_cyc();
        for (int k = 1; k <= 32; k++) begin
            i_rd_start   = (k == 16);
            i_load_valid = (k == 6);
            i_load_data  = (k == 6) ? 16'd315 : 16'd0;
            idx = (k - 1) % 16;
            smp();
            chk("mid_valid",   o_tap_valid, 1);
            chk("mid_idx",     o_tap_idx, idx);
            chk("mid_tap",     o_tap, (k <= 16) ? (100 + idx) : (300 + idx));
            chk("mid_last",    o_tap_last, (k == 16) || (k == 32));
            chk("mid_swapped", o_swapped, (k == 16));
            chk("mid_pending", o_commit_pending, (k >= 7) && (k <= 16));
            chk("mid_ready",   o_load_ready, (k <= 6));
            next_cyc();
        end
        idle_inputs();
        smp();
        chk("mid_end_valid", o_tap_valid, 0);
        chk("mid_end_bank",  o_bank, 0);
        next_cyc();
        $display("load-during-sweep committed at sweep boundary");

        // ---------------- Restart discards partial load ----------------
        i_load_start = 1'b1;
        smp();
        next_cyc();
        i_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 16'(400 + i);
            smp();
            chk("rs_ready1",   o_load_ready, 1);
            chk("rs_pending1", o_commit_pending, 0);
            next_cyc();
        end
        // The restart carries the first new word to index 0
        i_load_start = 1'b1;
        i_load_valid = 1'b1;
        i_load_data  = 16'd200;
        smp();
        chk("rs_ready_restart", o_load_ready, 1);
        next_cyc();
        i_load_start = 1'b0;
        for (int i = 1; i < N_TAPS; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 16'(200 + i);
            smp();
            chk("rs_ready2",   o_load_ready, 1);
            chk("rs_pending2", o_commit_pending, 0);
            chk("rs_swapped2", o_swapped, 0);
            next_cyc();
        end
        idle_inputs();
        smp();
        chk("rs_ready_lo", o_load_ready, 0);
        chk("rs_swapped",  o_swapped, 1);
        chk("rs_bank_old", o_bank, 0);
        next_cyc();
        smp();
        chk("rs_bank_new", o_bank, 1);
        next_cyc();
        $display("restarted load committed");
        sweep(1'b0, 200, "asc200");

        // ---------------- Continuous back-to-back sweeps with a load ----------------
        for (int k = 0; k <= 48; k++) begin
            i_rd_start   = (k == 0) || (k == 16) || (k == 32);
            i_load_start = (k == 1);
            i_load_valid = (k >= 2) && (k <= 17);
            i_load_data  = ((k >= 2) && (k <= 17)) ? 16'(500 + k - 2) : 16'd0;
            smp();
            if (k == 0) begin
                chk("b2b_busy0", o_busy, 0);
            end else begin
                idx = (k - 1) % 16;
                chk("b2b_valid",   o_tap_valid, 1);
                chk("b2b_idx",     o_tap_idx, idx);
                chk("b2b_tap",     o_tap, (k <= 32) ? (200 + idx) : (500 + idx));
                chk("b2b_last",    o_tap_last, (k % 16) == 0);
                chk("b2b_swapped", o_swapped, (k == 32));
                chk("b2b_pending", o_commit_pending, (k >= 18) && (k <= 32));
            end
            next_cyc();
        end
        idle_inputs();
        smp();
        chk("b2b_end_valid", o_tap_valid, 0);
        chk("b2b_end_bank",  o_bank, 0);
        next_cyc();
        $display("back-to-back sweeps with commit at boundary");

        // ---------------- Reset mid-load and mid-sweep ----------------
        i_load_start = 1'b1;
        i_rd_start   = 1'b1;
        smp();
        next_cyc();
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 16'(600 + i);
            smp();
            next_cyc();
        end
        idle_inputs();
        i_rst = 1'b1;
        smp();
        chk("mr_busy_before", o_busy, 1);
        next_cyc();
        i_rst = 1'b0;
        smp();
        chk("mr_bank",    o_bank, 0);
        chk("mr_ready",   o_load_ready, 0);
        chk("mr_pending", o_commit_pending, 0);
        chk("mr_swapped", o_swapped, 0);
        chk("mr_valid",   o_tap_valid, 0);
        chk("mr_last",    o_tap_last, 0);
        chk("mr_busy",    o_busy, 0);
        chk("mr_tap",     o_tap, 0);
        chk("mr_idx",     o_tap_idx, 0);
        next_cyc();
        $display("reset mid-load and mid-sweep");
        sweep(1'b0, -1, "post_rst");
        smp();
        chk("post_rst_pending", o_commit_pending, 0);
        chk("post_rst_bank",    o_bank, 0);
        next_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
